// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side request/response bundle for bus_host_arbiter.
// The slave modport is the arbiter's view; master is the environment driving hosts and device.
interface bus_host_arbiter_if #(
   parameter int NrHosts      = 2,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   logic [NrHosts-1:0]                    host_req_i;
   logic [NrHosts-1:0]                    host_gnt_o;
   logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i;
   logic [NrHosts-1:0]                    host_we_i;
   logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i;
   logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i;
   logic [NrHosts-1:0]                    host_rvalid_o;
   logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o;
   logic [NrHosts-1:0]                    host_err_o;

   logic                                  dev_req_o;
   logic                                  dev_gnt_i;
   logic [AddressWidth-1:0]               dev_addr_o;
   logic                                  dev_we_o;
   logic [DataWidth/8-1:0]                dev_be_o;
   logic [DataWidth-1:0]                  dev_wdata_o;
   logic                                  dev_rvalid_i;
   logic [DataWidth-1:0]                  dev_rdata_i;
   logic                                  dev_err_i;

   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
      input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
   );

   modport master (
      output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
      output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
   );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device port among NrHosts hosts, with an owner FIFO routing
// in-order responses back to the issuer. Define BUS_ARB_STATS_EN for per-host grant/wait counters.
module bus_host_arbiter #(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   bus_host_arbiter_if.slave     bus,
   output logic                  proto_err_o
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [NrHosts-1:0][15:0] grant_cnt_o,
   output logic [NrHosts-1:0][15:0] wait_cnt_o
`endif
);

   localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic {
      LockIdle,
      LockHeld
   } lock_state_e;

   lock_state_e      lockState_q, lockState_d;
   logic [IdW-1:0]   lockId_q, lockId_d;
   logic [IdW-1:0]   rrPtr_q, rrPtr_d;
   logic [IdW-1:0]   sel;
   logic             found;
   int               idx;
   logic [IdW-1:0]   idxSel;

   logic [IdW-1:0]   owner_q [MaxOutstanding];
   logic [PtrW-1:0]  wrPtr_q, rdPtr_q;
   logic [CntW-1:0]  count_q;
   logic             protoErr_q;

   logic             anyReq, fifoFull, fifoEmpty, devReq, accept, pop;
   logic [IdW-1:0]   headId;
   logic [NrHosts-1:0] hostGnt;

   function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
      return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
   endfunction

   // A pending unaccepted request keeps its host; otherwise scan from the pointer.
   always_comb begin
      sel    = rrPtr_q;
      found  = 1'b0;
      idx    = 0;
      idxSel = '0;
      if (lockState_q == LockHeld && bus.host_req_i[lockId_q]) begin
         sel   = lockId_q;
         found = 1'b1;
      end
      for (int k = 0; k < NrHosts; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= NrHosts) idx = idx - NrHosts;
         idxSel = IdW'(idx);
         if (!found && bus.host_req_i[idxSel]) begin
            sel   = idxSel;
            found = 1'b1;
         end
      end
   end

   assign anyReq    = |bus.host_req_i;
   assign fifoFull  = (count_q == CntW'(MaxOutstanding));
   assign fifoEmpty = (count_q == '0);
   assign devReq    = !rst_i && anyReq && !fifoFull;
   assign accept    = devReq && bus.dev_gnt_i;
   assign pop       = !rst_i && bus.dev_rvalid_i && !fifoEmpty;
   assign headId    = owner_q[rdPtr_q];

   assign bus.dev_req_o   = devReq;
   assign bus.dev_addr_o  = rst_i ? '0 : bus.host_addr_i[sel];
   assign bus.dev_we_o    = rst_i ? 1'b0 : bus.host_we_i[sel];
   assign bus.dev_be_o    = rst_i ? '0 : bus.host_be_i[sel];
   assign bus.dev_wdata_o = rst_i ? '0 : bus.host_wdata_i[sel];
   assign proto_err_o     = protoErr_q && !rst_i;

   always_comb begin
      hostGnt           = '0;
      bus.host_rvalid_o = '0;
      bus.host_err_o    = '0;
      if (accept) hostGnt[sel] = 1'b1;
      if (pop) begin
         bus.host_rvalid_o[headId] = 1'b1;
         bus.host_err_o[headId]    = bus.dev_err_i;
      end
   end

   assign bus.host_gnt_o = hostGnt;

   always_comb begin
      for (int i = 0; i < NrHosts; i++) begin
         bus.host_rdata_o[i] = rst_i ? '0 : bus.dev_rdata_i;
      end
   end

   // Lock holds the selection while the device stalls a presented request.
   always_comb begin
      lockState_d = LockIdle;
      lockId_d    = lockId_q;
      rrPtr_d     = rrPtr_q;
      if (devReq && !bus.dev_gnt_i) begin
         lockState_d = LockHeld;
         lockId_d    = sel;
      end
      if (accept) begin
         rrPtr_d = (int'(sel) == NrHosts - 1) ? '0 : sel + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lockState_q <= LockIdle;
         lockId_q    <= '0;
         rrPtr_q     <= '0;
      end else begin
         lockState_q <= lockState_d;
         lockId_q    <= lockId_d;
         rrPtr_q     <= rrPtr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MaxOutstanding; i++) owner_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         protoErr_q <= 1'b0;
      end else begin
         if (accept) begin
            owner_q[wrPtr_q] <= sel;
            wrPtr_q          <= incPtr(wrPtr_q);
         end
         if (pop) rdPtr_q <= incPtr(rdPtr_q);
         case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.dev_rvalid_i && fifoEmpty) protoErr_q <= 1'b1;
      end
   end

`ifdef BUS_ARB_STATS_EN
   logic [NrHosts-1:0][15:0] grantCnt_q, waitCnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grantCnt_q <= '0;
         waitCnt_q  <= '0;
      end else begin
         for (int i = 0; i < NrHosts; i++) begin
            if (hostGnt[i] && grantCnt_q[i] != 16'hFFFF)
               grantCnt_q[i] <= grantCnt_q[i] + 16'd1;
            if (bus.host_req_i[i] && !hostGnt[i] && waitCnt_q[i] != 16'hFFFF)
               waitCnt_q[i] <= waitCnt_q[i] + 16'd1;
         end
      end
   end

   assign grant_cnt_o = grantCnt_q;
   assign wait_cnt_o  = waitCnt_q;
`endif

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter: a per-cycle vector table plus hand-written lock and
// mid-transaction reset sequences, all with hand-computed expectations.
module tb_bus_host_arbiter;

   localparam int NrHosts = 2;
   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int MaxOut  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic protoErr;
   int   checks = 0;
   int   passed = 0;

`ifdef BUS_ARB_STATS_EN
   logic [NrHosts-1:0][15:0] grantCnt, waitCnt;
`endif

   bus_host_arbiter_if #(.NrHosts(NrHosts), .DataWidth(DW), .AddressWidth(AW)) bus ();

   bus_host_arbiter #(
      .NrHosts(NrHosts), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MaxOut)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus.slave),
      .proto_err_o(protoErr)
`ifdef BUS_ARB_STATS_EN
      ,
      .grant_cnt_o(grantCnt),
      .wait_cnt_o (waitCnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic        gnt;
      logic        rv;
      logic        err;
      logic        expReq;
      logic [1:0]  expGnt;
      logic [1:0]  expRv;
      logic [1:0]  expErr;
      logic        expProto;
      logic [31:0] expAddr;
   } vec_t;

   vec_t vecs [18];

   // Drive one cycle of inputs just after the falling edge.
   task automatic applyStimulus(input logic r, input logic [1:0] req, input logic g,
                                input logic rv, input logic e);
      @(negedge clk);
      rst              = r;
      bus.host_req_i   = req;
      bus.dev_gnt_i    = g;
      bus.dev_rvalid_i = rv;
      bus.dev_err_i    = e;
   endtask

   // Compare combinational outputs once they settle, well before the next rising edge.
   task automatic checkOutput(input string name, input logic expReq, input logic [1:0] expGnt,
                              input logic [1:0] expRv, input logic [1:0] expErr,
                              input logic expProto, input logic [31:0] expAddr);
      #1;
      checks++;
      if ({bus.dev_req_o, bus.host_gnt_o, bus.host_rvalid_o, bus.host_err_o, protoErr} !==
          {expReq, expGnt, expRv, expErr, expProto}) begin
         $display("[TB] FAIL %s: req/gnt/rvalid/err/proto got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                  name, bus.dev_req_o, bus.host_gnt_o, bus.host_rvalid_o, bus.host_err_o, protoErr,
                  expReq, expGnt, expRv, expErr, expProto);
      end else begin
         passed++;
      end
      if (expReq) begin
         checks++;
         if (bus.dev_addr_o !== expAddr)
            $display("[TB] FAIL %s_addr: got %h want %h", name, bus.dev_addr_o, expAddr);
         else
            passed++;
      end
   endtask

   initial begin
      bus.host_req_i      = '0;
      bus.host_addr_i[0]  = 32'h0000_0100;
      bus.host_addr_i[1]  = 32'h0000_0200;
      bus.host_we_i       = 2'b01;
      bus.host_be_i       = '1;
      bus.host_wdata_i[0] = 32'hAAAA_AAAA;
      bus.host_wdata_i[1] = 32'h5555_5555;
      bus.dev_gnt_i       = 1'b0;
      bus.dev_rvalid_i    = 1'b0;
      bus.dev_rdata_i     = 32'hCAFE_0000;
      bus.dev_err_i       = 1'b0;

      // rst req gnt rv err | req gnt rvalid err proto addr
      vecs[0]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100};
      vecs[3]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0, 32'h200};
      vecs[4]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0, 32'h100};
      vecs[5]  = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 1'b0, 32'h200};
      vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100};
      vecs[8]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100};
      vecs[9]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0};
      vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0};
      vecs[16] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
      vecs[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].err);
         checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expGnt, vecs[i].expRv,
                     vecs[i].expErr, vecs[i].expProto, vecs[i].expAddr);
      end

      // Host 1 stalled three cycles; host 0 arriving with the pointer at 0 must not steal it.
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
      checkOutput("lockA", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'h200);
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
      checkOutput("lockB", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'h200);
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
      checkOutput("lockC", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'h200);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("lockD", 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 32'h200);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("lockE", 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      checkOutput("lockF", 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 32'h0);
      checks++;
      if (bus.host_rdata_o[1] !== 32'hCAFE_0000)
         $display("[TB] FAIL rdata: got %h want %h", bus.host_rdata_o[1], 32'hCAFE_0000);
      else
         passed++;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      checkOutput("lockG", 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("lockH", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

      // Two outstanding from host 0 (pointer left at 1), then reset mid-transaction.
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
      checkOutput("rstI", 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
      checkOutput("rstJ", 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100);
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("rstK", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("rstL", 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h100);
`ifdef BUS_ARB_STATS_EN
      checks++;
      if ({grantCnt, waitCnt} !== '0)
         $display("[TB] FAIL statsReset: grant %h wait %h want 0", grantCnt, waitCnt);
      else
         passed++;
`endif
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      checkOutput("rstM", 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      checkOutput("rstN", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("rstO", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
